// File: rtl/button_debounce.sv
// Push-button conditioner: synchroniser, debounce filter, press/release pulses
// and a once-per-press long-press detector.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES   = 1000000,
    parameter int SYNC_STAGES       = 2,
    parameter int LONG_PRESS_CYCLES = 50000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic long_press_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);

    typedef enum logic [1:0] {
        RELEASED,
        PRESSED,
        LONG_HELD
    } state_t;

    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   sync;
    logic [CW-1:0]          cnt;
    logic                   accept;
    logic                   rise;
    logic                   fall;
    state_t                 state;
    state_t                 state_next;
    logic [HW-1:0]          hold_cnt;
    logic [HW-1:0]          hold_next;
    logic                   long_next;

    // btn_i lands directly on the first flop of the chain
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_ff <= '0;
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], btn_i};
        end
    end

    assign sync   = sync_ff[SYNC_STAGES-1];
    assign accept = (sync != level_o) && (cnt == CNT_LAST);
    assign rise   = accept && sync;
    assign fall   = accept && !sync;

    // Any cycle that agrees with the current level restarts the stability count
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            level_o   <= 1'b0;
            press_o   <= 1'b0;
            release_o <= 1'b0;
        end else begin
            press_o   <= rise;
            release_o <= fall;
            if (sync == level_o) begin
                cnt <= '0;
            end else if (accept) begin
                level_o <= sync;
                cnt     <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RELEASED;
            hold_cnt     <= '0;
            long_press_o <= 1'b0;
        end else begin
            state        <= state_next;
            hold_cnt     <= hold_next;
            long_press_o <= long_next;
        end
    end

    // A release on the terminal edge takes priority over the long-press pulse
    always_comb begin
        state_next = state;
        hold_next  = hold_cnt;
        long_next  = 1'b0;
        case (state)
            RELEASED: begin
                if (rise) begin
                    state_next = PRESSED;
                    hold_next  = '0;
                end
            end
            PRESSED: begin
                if (fall) begin
                    state_next = RELEASED;
                end else if (hold_cnt == HOLD_LAST) begin
                    state_next = LONG_HELD;
                    long_next  = 1'b1;
                end else begin
                    hold_next = hold_cnt + HW'(1);
                end
            end
            LONG_HELD: begin
                if (fall) begin
                    state_next = RELEASED;
                end
            end
            default: begin
                state_next = RELEASED;
            end
        endcase
    end

endmodule

// File: tb/tb_button_debounce.sv
// Randomised bench for button_debounce, compared each cycle against a
// history-window model of the debounce and long-press rules.
module tb_button_debounce;

    localparam int DEB  = 4;
    localparam int SYNC = 2;
    localparam int LP   = 8;
    localparam int MAXE = 8192;

    logic clk = 1'b0;
    logic rst;
    logic btn;
    logic level;
    logic press;
    logic rel;
    logic longp;

    int vectors     = 0;
    int miscompares = 0;
    int edgeNo      = 0;
    int lastReset   = 0;
    int lastEvent   = 0;
    int riseEdge    = -100000;

    bit btnHist [0:MAXE-1];
    bit mLevel   = 1'b0;
    bit ePress   = 1'b0;
    bit eRelease = 1'b0;
    bit eLong    = 1'b0;

    always #5 clk = ~clk;

    button_debounce #(
        .DEBOUNCE_CYCLES  (DEB),
        .SYNC_STAGES      (SYNC),
        .LONG_PRESS_CYCLES(LP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_i       (btn),
        .level_o     (level),
        .press_o     (press),
        .release_o   (rel),
        .long_press_o(longp)
    );

    // Synchronised value the filter sees at edge m: the raw sample SYNC edges earlier
    function automatic bit syncVis(input int m);
        if ((m - SYNC > lastReset) && (m - SYNC >= 0))
            return btnHist[m - SYNC];
        return 1'b0;
    endfunction

    task automatic modelStep(input bit b, input bit r);
        bit accept;
        edgeNo++;
        ePress   = 1'b0;
        eRelease = 1'b0;
        eLong    = 1'b0;
        if (r) begin
            lastReset = edgeNo;
            lastEvent = edgeNo;
            mLevel    = 1'b0;
            riseEdge  = -100000;
        end else begin
            btnHist[edgeNo] = b;
            accept = (edgeNo - DEB + 1 > lastEvent);
            for (int k = 0; k < DEB; k++)
                if (syncVis(edgeNo - k) == mLevel) accept = 1'b0;
            if (accept) begin
                mLevel    = !mLevel;
                lastEvent = edgeNo;
                if (mLevel) begin
                    ePress   = 1'b1;
                    riseEdge = edgeNo;
                end else begin
                    eRelease = 1'b1;
                end
            end else begin
                eLong = mLevel && (edgeNo == riseEdge + LP);
            end
        end
    endtask

    task automatic checkOutput(input string tag, input logic obs, input logic exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s at edge %0d: got %b expected %b", tag, edgeNo, obs, exp);
        end
    endtask

    task automatic applyStimulus(input bit b, input bit r);
        if (edgeNo >= MAXE - 2) begin
            $display("[TB] FAIL history: edge budget %0d exhausted", MAXE);
            $fatal(1, "[TB] stimulus too long");
        end
        @(negedge clk);
        btn = b;
        rst = r;
        @(posedge clk);
        modelStep(b, r);
        #1;
        checkOutput("level", level, mLevel);
        checkOutput("press", press, ePress);
        checkOutput("release", rel, eRelease);
        checkOutput("long_press", longp, eLong);
    endtask

    task automatic holdBtn(input bit b, input int n);
        repeat (n) applyStimulus(b, 1'b0);
    endtask

    initial begin
        int lens [3];
        rst = 1'b1;
        btn = 1'b0;

        for (int i = 0; i < 3; i++) applyStimulus(bit'(i % 2), 1'b1);

        // Long hold then release
        holdBtn(1'b1, 30);
        holdBtn(1'b0, 20);

        // Short glitch that must be filtered
        holdBtn(1'b1, 3);
        holdBtn(1'b0, 10);

        // Chatter, then a settled press
        for (int i = 0; i < 12; i++) applyStimulus(bit'(i % 2), 1'b0);
        holdBtn(1'b1, 20);
        holdBtn(1'b0, 15);

        // Reset in the middle of a press
        holdBtn(1'b1, 10);
        applyStimulus(1'b1, 1'b1);
        holdBtn(1'b1, 15);
        holdBtn(1'b0, 15);

        // Release landing just before, on, and just after the long-press edge
        lens[0] = 7;
        lens[1] = 8;
        lens[2] = 9;
        for (int i = 0; i < 3; i++) begin
            holdBtn(1'b1, lens[i]);
            holdBtn(1'b0, 12);
        end

        repeat (250) begin
            if ($urandom_range(0, 29) == 0)
                applyStimulus(bit'($urandom_range(0, 1)), 1'b1);
            else
                holdBtn(bit'($urandom_range(0, 1)), int'($urandom_range(1, 14)));
        end
        holdBtn(1'b0, 12);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
